// File: rtl/regfile_pkg.sv
// Shared constants for the 32x32 register file with per-register pending
// (scoreboard) bits. Used by the decode/read side and the write-back side.
//
// Contents:
//   DATA_WIDTH - register and data-port width
//   NUM_REGS   - number of architectural registers
//   IDX_WIDTH  - width of every register select port
//   ZERO_REG   - index of the hardwired-zero register
package regfile_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int NUM_REGS   = 32;
    localparam int IDX_WIDTH  = 5;

    localparam logic [IDX_WIDTH-1:0] ZERO_REG = '0;

endpackage

// File: rtl/regfile_32x32_register32.sv
// register32: one storage register of the register file.
// Loads data_i on the rising clock edge when enable_i is high; a synchronous
// active-high reset clears it and takes priority over the load.
//
// Ports:
//   clock    - rising-edge clock
//   reset    - synchronous, active-high clear
//   enable_i - load strobe
//   data_i   - value to load
//   data_o   - stored value
module register32
    import regfile_pkg::*;
#(
    parameter int WIDTH = regfile_pkg::DATA_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    // Hold the current value unless this register is the write target.
    always_comb begin
        data_d = data_q;
        if (enable_i) begin
            data_d = data_i;
        end
    end

    // Reset discards any load presented on the same edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/regfile_32x32.sv
// regfile_32x32: two-read / one-write register file with a pending-producer
// bit per register. Register 0 is hardwired to zero and is never busy.
// Reads and busy lookups are combinational; writes and issues update state
// on the rising clock edge.
//
// Optional feature (macro REGFILE_WRITE_BYPASS_EN): a read port selecting the
// register being written this cycle returns the incoming write data, and its
// busy output reflects only a same-edge issue to that register. Without the
// macro, reads show stored state only.
//
// Ports:
//   clock, reset              - rising-edge clock, synchronous active-high reset
//   ctrl_writeEnable/Reg      - write strobe and target index
//   data_writeReg             - write data
//   ctrl_readRegA/B           - read-port indices
//   ctrl_issueEnable/Reg      - mark a register as having a pending producer
//   data_readRegA/B           - read-port data
//   busyA, busyB              - pending bit of the selected register
module regfile_32x32
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = regfile_pkg::DATA_WIDTH,
    parameter int NUM_REGS   = regfile_pkg::NUM_REGS
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  ctrl_writeEnable,
    input  logic [IDX_WIDTH-1:0]  ctrl_writeReg,
    input  logic [DATA_WIDTH-1:0] data_writeReg,
    input  logic [IDX_WIDTH-1:0]  ctrl_readRegA,
    input  logic [IDX_WIDTH-1:0]  ctrl_readRegB,
    input  logic                  ctrl_issueEnable,
    input  logic [IDX_WIDTH-1:0]  ctrl_issueReg,
    output logic [DATA_WIDTH-1:0] data_readRegA,
    output logic [DATA_WIDTH-1:0] data_readRegB,
    output logic                  busyA,
    output logic                  busyB
);

    logic [DATA_WIDTH-1:0] regValue [NUM_REGS];
    logic [NUM_REGS-1:0]   pending_q;
    logic [NUM_REGS-1:0]   pending_d;
    logic                  writeCommit;
    logic                  issueValid;
    logic                  bypassA;
    logic                  bypassB;

    assign writeCommit = ctrl_writeEnable && (ctrl_writeReg != ZERO_REG);
    assign issueValid  = ctrl_issueEnable && (ctrl_issueReg != ZERO_REG);

    // Register 0 has no storage; it always reads as zero.
    assign regValue[0] = '0;

    for (genvar i = 1; i < NUM_REGS; i++) begin : gen_regs
        logic writeHit;
        assign writeHit = ctrl_writeEnable && (ctrl_writeReg == IDX_WIDTH'(i));
        register32 #(.WIDTH(DATA_WIDTH)) u_reg (
            .clock    (clock),
            .reset    (reset),
            .enable_i (writeHit),
            .data_i   (data_writeReg),
            .data_o   (regValue[i])
        );
    end

    // The write clears its target first, then the issue sets its target, so a
    // same-index issue overrides the clear: the issue is the newer producer.
    always_comb begin
        pending_d = pending_q;
        if (writeCommit) begin
            pending_d[ctrl_writeReg] = 1'b0;
        end
        if (issueValid) begin
            pending_d[ctrl_issueReg] = 1'b1;
        end
        pending_d[ZERO_REG] = 1'b0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    // A port bypasses when it selects the register being written right now.
`ifdef REGFILE_WRITE_BYPASS_EN
    assign bypassA = writeCommit && (ctrl_readRegA == ctrl_writeReg);
    assign bypassB = writeCommit && (ctrl_readRegB == ctrl_writeReg);
`else
    assign bypassA = 1'b0;
    assign bypassB = 1'b0;
`endif

    // When bypassing, the stored pending bit is about to be cleared by the
    // write, so only a same-edge issue to that index keeps the port busy.
    always_comb begin
        data_readRegA = regValue[ctrl_readRegA];
        busyA         = pending_q[ctrl_readRegA];
        if (bypassA) begin
            data_readRegA = data_writeReg;
            busyA         = issueValid && (ctrl_issueReg == ctrl_readRegA);
        end
    end

    always_comb begin
        data_readRegB = regValue[ctrl_readRegB];
        busyB         = pending_q[ctrl_readRegB];
        if (bypassB) begin
            data_readRegB = data_writeReg;
            busyB         = issueValid && (ctrl_issueReg == ctrl_readRegB);
        end
    end

endmodule

// File: tb/tb_regfile_32x32.sv
// Self-checking bench for regfile_32x32: directed scenarios followed by
// randomized traffic, compared against an array-based reference model.
module tb_regfile_32x32;

    logic        clock;
    logic        reset;
    logic        ctrl_writeEnable;
    logic [4:0]  ctrl_writeReg;
    logic [31:0] data_writeReg;
    logic [4:0]  ctrl_readRegA;
    logic [4:0]  ctrl_readRegB;
    logic        ctrl_issueEnable;
    logic [4:0]  ctrl_issueReg;
    logic [31:0] data_readRegA;
    logic [31:0] data_readRegB;
    logic        busyA;
    logic        busyB;

    int testsRun    = 0;
    int testsFailed = 0;

    logic [31:0] modelRegs [32];
    bit          modelBusy [32];

    regfile_32x32 dut (
        .clock            (clock),
        .reset            (reset),
        .ctrl_writeEnable (ctrl_writeEnable),
        .ctrl_writeReg    (ctrl_writeReg),
        .data_writeReg    (data_writeReg),
        .ctrl_readRegA    (ctrl_readRegA),
        .ctrl_readRegB    (ctrl_readRegB),
        .ctrl_issueEnable (ctrl_issueEnable),
        .ctrl_issueReg    (ctrl_issueReg),
        .data_readRegA    (data_readRegA),
        .data_readRegB    (data_readRegB),
        .busyA            (busyA),
        .busyB            (busyB)
    );

    // 10-unit clock period, first rising edge at t=5.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Safety net so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    // Reference read: register 0 is zero; with bypass, the in-flight write is visible.
    function automatic logic [31:0] expectedData(input logic [4:0] idx);
        if (idx == 5'd0) return 32'd0;
`ifdef REGFILE_WRITE_BYPASS_EN
        if (ctrl_writeEnable && ctrl_writeReg == idx) return data_writeReg;
`endif
        return modelRegs[idx];
    endfunction

    function automatic logic [31:0] expectedBusy(input logic [4:0] idx);
        if (idx == 5'd0) return 32'd0;
`ifdef REGFILE_WRITE_BYPASS_EN
        if (ctrl_writeEnable && ctrl_writeReg == idx)
            return {31'd0, ctrl_issueEnable && ctrl_issueReg == idx};
`endif
        return {31'd0, modelBusy[idx]};
    endfunction

    // Drive one cycle's inputs, then compare both ports against the model.
    task automatic applyStimulus(input logic rst, input logic we, input logic [4:0] wr,
                                 input logic [31:0] wd, input logic ie, input logic [4:0] ir,
                                 input logic [4:0] ra, input logic [4:0] rb);
        reset            = rst;
        ctrl_writeEnable = we;
        ctrl_writeReg    = wr;
        data_writeReg    = wd;
        ctrl_issueEnable = ie;
        ctrl_issueReg    = ir;
        ctrl_readRegA    = ra;
        ctrl_readRegB    = rb;
        #2;
        checkOutput("dataA", data_readRegA, expectedData(ra));
        checkOutput("dataB", data_readRegB, expectedData(rb));
        checkOutput("busyA", {31'd0, busyA}, expectedBusy(ra));
        checkOutput("busyB", {31'd0, busyB}, expectedBusy(rb));
    endtask

    // Advance one rising edge and apply the architectural effect of the held inputs.
    task automatic tick();
        @(posedge clock);
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                modelRegs[i] = 32'd0;
                modelBusy[i] = 1'b0;
            end
        end else begin
            if (ctrl_writeEnable && ctrl_writeReg != 5'd0) begin
                modelRegs[ctrl_writeReg] = data_writeReg;
                modelBusy[ctrl_writeReg] = 1'b0;
            end
            if (ctrl_issueEnable && ctrl_issueReg != 5'd0)
                modelBusy[ctrl_issueReg] = 1'b1;
        end
        #1;
    endtask

    task automatic cycle(input logic rst, input logic we, input logic [4:0] wr,
                         input logic [31:0] wd, input logic ie, input logic [4:0] ir,
                         input logic [4:0] ra, input logic [4:0] rb);
        applyStimulus(rst, we, wr, wd, ie, ir, ra, rb);
        tick();
    endtask

    task automatic readIdle(input logic [4:0] ra, input logic [4:0] rb);
        applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, ra, rb);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            modelRegs[i] = 32'hXXXXXXXX;
            modelBusy[i] = 1'b0;
        end
        reset = 1'b1;
        ctrl_writeEnable = 1'b0;
        ctrl_writeReg = '0;
        data_writeReg = '0;
        ctrl_issueEnable = 1'b0;
        ctrl_issueReg = '0;
        ctrl_readRegA = '0;
        ctrl_readRegB = '0;
        #1;

        // Reset, then sweep every index on both ports.
        tick();
        for (int i = 0; i < 32; i++) begin
            readIdle(5'(i), 5'(31 - i));
            checkOutput("rstDataA", data_readRegA, 32'd0);
            checkOutput("rstBusyB", {31'd0, busyB}, 32'd0);
            tick();
        end

        // Basic write and zero-register write.
        cycle(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 5'd1, 5'd2);
        readIdle(5'd5, 5'd0);
        checkOutput("r5", data_readRegA, 32'hDEADBEEF);
        checkOutput("r0B", data_readRegB, 32'd0);
        tick();
        cycle(1'b0, 1'b1, 5'd0, 32'h1234, 1'b0, 5'd0, 5'd1, 5'd2);
        readIdle(5'd0, 5'd0);
        checkOutput("r0wr", data_readRegA, 32'd0);
        tick();

        // Issue then later write clears busy.
        cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 5'd1, 5'd2);
        readIdle(5'd7, 5'd7);
        checkOutput("r7busy", {31'd0, busyA}, 32'd1);
        tick();
        cycle(1'b0, 1'b1, 5'd7, 32'h55, 1'b0, 5'd0, 5'd1, 5'd2);
        readIdle(5'd7, 5'd1);
        checkOutput("r7data", data_readRegA, 32'h55);
        checkOutput("r7free", {31'd0, busyA}, 32'd0);
        tick();

        // Same-edge issue and write: issue wins; different indices both apply.
        cycle(1'b0, 1'b1, 5'd9, 32'hAA, 1'b1, 5'd9, 5'd1, 5'd2);
        readIdle(5'd9, 5'd9);
        checkOutput("r9data", data_readRegA, 32'hAA);
        checkOutput("r9busy", {31'd0, busyB}, 32'd1);
        tick();
        cycle(1'b0, 1'b1, 5'd4, 32'h4444, 1'b1, 5'd3, 5'd1, 5'd2);
        readIdle(5'd3, 5'd4);
        checkOutput("r3busy", {31'd0, busyA}, 32'd1);
        checkOutput("r4data", data_readRegB, 32'h4444);
        tick();

        // Same-cycle read of the register being written.
        cycle(1'b0, 1'b1, 5'd12, 32'h11, 1'b0, 5'd0, 5'd1, 5'd2);
        applyStimulus(1'b0, 1'b1, 5'd12, 32'h77, 1'b0, 5'd0, 5'd12, 5'd12);
`ifdef REGFILE_WRITE_BYPASS_EN
        checkOutput("r12byp", data_readRegA, 32'h77);
`else
        checkOutput("r12old", data_readRegA, 32'h11);
`endif
        tick();
        readIdle(5'd12, 5'd0);
        checkOutput("r12new", data_readRegA, 32'h77);
        tick();

        // Fill and pend r1-r31, then reset with a write and issue on the same edge.
        for (int i = 1; i < 32; i++)
            cycle(1'b0, 1'b1, 5'(i), 32'(i), 1'b1, 5'(i), 5'(i), 5'(32 - i));
        readIdle(5'd31, 5'd17);
        checkOutput("r31fill", data_readRegA, 32'd31);
        checkOutput("r17pend", {31'd0, busyB}, 32'd1);
        tick();
        cycle(1'b1, 1'b1, 5'd10, 32'hFFFF, 1'b1, 5'd11, 5'd1, 5'd2);
        for (int i = 0; i < 32; i++) begin
            readIdle(5'(i), 5'(i));
            checkOutput("clrData", data_readRegA, 32'd0);
            checkOutput("clrBusy", {31'd0, busyB}, 32'd0);
            tick();
        end

        // Randomized traffic with occasional mid-sequence resets.
        for (int n = 0; n < 400; n++) begin
            cycle(($urandom_range(0, 39) == 0), 1'($urandom), 5'($urandom),
                  $urandom, 1'($urandom), 5'($urandom),
                  5'($urandom), 5'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/regfile_32x32.md
REGFILE_32X32 -- requirements
Module: regfile_32x32

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, register and data-port width.
REQ-002 SHALL have parameter NUM_REGS, default 32, register count; select ports are log2(NUM_REGS) = 5 bits.
REQ-003 SHALL have one clock and one reset: the reset is synchronous and active-high.
REQ-004 clock  input  1  rising-edge clock for all state.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 ctrl_writeEnable  input  1  write-port strobe.
REQ-007 ctrl_writeReg  input  5  write-port register index.
REQ-008 data_writeReg  input  32  write-port data.
REQ-009 ctrl_readRegA  input  5  read-port A index.
REQ-010 ctrl_readRegB  input  5  read-port B index.
REQ-011 ctrl_issueEnable  input  1  marks a register as having a pending producer.
REQ-012 ctrl_issueReg  input  5  index that ctrl_issueEnable marks pending.
REQ-013 data_readRegA  output  32  read-port A data.
REQ-014 data_readRegB  output  32  read-port B data.
REQ-015 busyA  output  1  pending bit of ctrl_readRegA.
REQ-016 busyB  output  1  pending bit of ctrl_readRegB.

Function
REQ-017 SHALL hold NUM_REGS x DATA_WIDTH registers; a write commits on the rising edge when ctrl_writeEnable=1 and ctrl_writeReg!=0.
REQ-018 SHALL treat register 0 as hardwired zero: writes are discarded, reads return 0, busy is always 0.
REQ-019 SHALL make read ports combinational from the array (zero-cycle read latency); both ports are fully independent and may select the same index.
REQ-020 SHALL make busyA/busyB combinational lookups of a 32-bit pending vector.
REQ-021 SHALL set pending[ctrl_issueReg] on the edge with ctrl_issueEnable=1 (index 0 ignored).
REQ-022 SHALL clear pending[ctrl_writeReg] on a committing write edge.
REQ-023 SHALL leave the pending bit set when an issue and a write target the same index on the same edge; issue wins because it represents the newer producer.
REQ-024 SHALL update both the issue and the write on the same edge when they target different indices.
REQ-025 SHALL let a write to a non-pending register commit data without any error indication.

Reset
REQ-026 SHALL, on an edge with reset=1, clear all registers and all pending bits; writes and issues on that edge are discarded.
REQ-027 SHALL, after reset, drive data_readRegA/B = 0 and busyA/B = 0 for every index.
REQ-028 SHALL accept a reset that arrives mid-sequence with no requirement beyond REQ-026; state before that edge is irrelevant.

Configuration
REQ-029 SHALL provide macro REGFILE_WRITE_BYPASS_EN.
REQ-030 With the macro defined, a read port whose index equals ctrl_writeReg (nonzero) while ctrl_writeEnable=1 SHALL return data_writeReg in the same cycle, and its busy output SHALL read 0 unless the same-edge issue in REQ-023 applies.
REQ-031 Without the macro, a read port SHALL return the stored value and the stored pending bit; new data is visible on the cycle after the write edge.

Structure
REQ-032 SHALL place DATA_WIDTH, NUM_REGS, the 5-bit index width and the zero-register index in a shared package, regfile_pkg, used by the decode and write-back stages.
REQ-033 SHALL build each register from one sub-module, register32: a 32-bit register with enable and synchronous active-high reset; read selection is a 32:1 selector per port.

Verification
REQ-034 Reset, then read all indices on A and B -> all data 0, busy 0.
REQ-035 Write 0xDEADBEEF to r5; read A=5, B=0 next cycle -> A=0xDEADBEEF, B=0. Write 0x1234 to r0 -> r0 still reads 0.
REQ-036 Issue r7, then write 0x55 to r7 on a later edge -> busy=1 between the two edges, busy=0 after the write edge.
REQ-037 Issue r9 and write 0xAA to r9 on the same edge -> r9=0xAA, busy stays 1. Issue r3 and write r4 on the same edge -> r3 busy=1, r4 data updated.
REQ-038 Write 0x77 to r12 while reading A=12 in the same cycle -> 0x77 with REGFILE_WRITE_BYPASS_EN defined, previous value without it.
REQ-039 Fill r1-r31 with their index values, pend r1-r31, then assert reset with a write and an issue pending on that edge -> all registers 0, all busy 0, and the write and issue are discarded.
